// File: rtl/control_unit_pkg.sv
// Shared definitions for the control_unit microsequencer: state encodings,
// ALU op codes, register-bank addresses, opcode classes and the control word.
package control_unit_pkg;

   localparam int unsigned OPC_W   = 5;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned SHAMT_W = 2;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned FLAG_W  = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT = 4'd0,
      ST_IDLE = 4'd1,
      ST_F0   = 4'd2,
      ST_F1   = 4'd3,
      ST_F2   = 4'd4,
      ST_DEC  = 4'd5,
      ST_EX   = 4'd6,
      ST_M0   = 4'd7,
      ST_M1   = 4'd8,
      ST_M2   = 4'd9,
      ST_SK   = 4'd10,
      ST_HALT = 4'd11
   } state_e;

   // ALU operations used directly by the sequencer
   localparam logic [SEL_W-1:0] SEL_PASS_B = 3'b000;
   localparam logic [SEL_W-1:0] SEL_INC_B  = 3'b110;

   // Register-bank addresses
   localparam logic [ADDR_W-1:0] REG_PC   = 3'b000;
   localparam logic [ADDR_W-1:0] REG_DPTR = 3'b001;
   localparam logic [ADDR_W-1:0] REG_A    = 3'b011;
   localparam logic [ADDR_W-1:0] REG_ACC  = 3'b111;

   // Opcode classes (instruction[4:3]) and fully decoded opcodes
   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_MOV = 2'b01;
   localparam logic [1:0] CLS_MEM = 2'b10;
   localparam logic [1:0] CLS_CTL = 2'b11;

   localparam logic [OPC_W-1:0] OPC_LOAD  = 5'b10000;
   localparam logic [OPC_W-1:0] OPC_STORE = 5'b10100;
   localparam logic [OPC_W-1:0] OPC_HALT  = 5'b11111;

   typedef struct packed {
      logic               ir_sclr;
      logic               mar_sclr;
      logic               enaf;
      logic [SEL_W-1:0]   selop;
      logic [SHAMT_W-1:0] shamt;
      logic               bank_wr_en;
      logic [ADDR_W-1:0]  busb_addr;
      logic [ADDR_W-1:0]  busc_addr;
      logic               ir_en;
      logic               mar_en;
      logic               mdr_en;
      logic               wr_rdn;
      logic               mdr_alu_n;
      logic               halted;
   } ctrl_t;

   // State entered from DEC for a given opcode; unlisted opcodes run as a NOP in EX
   function automatic state_e exec_state(input logic [OPC_W-1:0] instr);
      state_e st;
      st = ST_EX;
      case (instr[4:3])
         CLS_MEM: begin
            if (instr == OPC_LOAD || instr == OPC_STORE) st = ST_M0;
         end
         CLS_CTL: begin
            if (instr == OPC_HALT) st = ST_HALT;
            else if (!instr[2])    st = ST_SK;
         end
         default: st = ST_EX;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational control-word decoder for control_unit.
// Ports:
//   state_i       current sequencer state
//   instruction_i IR opcode
//   flags_i       {Z,P,N,C}, indexed by the SKIP flag select
//   ctrl_o        control word for this cycle (unused fields 0)
module control_unit_decoder
   import control_unit_pkg::*;
#(
   parameter logic [SHAMT_W-1:0] SHIFT_AMT = 2'd1
) (
   input  state_e             state_i,
   input  logic [OPC_W-1:0]   instruction_i,
   input  logic [FLAG_W-1:0]  flags_i,
   output ctrl_t              ctrl_o
);

   logic is_store;
   assign is_store = (instruction_i == OPC_STORE);

   // Moore decode: every field defaults to 0, each state sets only what it uses
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_INIT: begin
            ctrl_o.ir_sclr  = 1'b1;
            ctrl_o.mar_sclr = 1'b1;
         end
         ST_F0: begin
            ctrl_o.busb_addr = REG_PC;
            ctrl_o.selop     = SEL_PASS_B;
            ctrl_o.mar_en    = 1'b1;
         end
         ST_F1: begin
            ctrl_o.mdr_alu_n = 1'b1;
            ctrl_o.mdr_en    = 1'b1;
         end
         ST_F2: begin
            ctrl_o.ir_en      = 1'b1;
            ctrl_o.busb_addr  = REG_PC;
            ctrl_o.selop      = SEL_INC_B;
            ctrl_o.busc_addr  = REG_PC;
            ctrl_o.bank_wr_en = 1'b1;
         end
         ST_EX: begin
            case (instruction_i[4:3])
               CLS_ALU: begin
                  ctrl_o.selop      = instruction_i[2:0];
                  ctrl_o.busb_addr  = REG_A;
                  ctrl_o.busc_addr  = REG_ACC;
                  ctrl_o.bank_wr_en = 1'b1;
                  ctrl_o.enaf       = 1'b1;
                  ctrl_o.shamt      = SHIFT_AMT;
               end
               CLS_MOV: begin
                  ctrl_o.busb_addr  = REG_ACC;
                  ctrl_o.selop      = SEL_PASS_B;
                  ctrl_o.busc_addr  = instruction_i[2:0];
                  ctrl_o.bank_wr_en = 1'b1;
               end
               default: ;
            endcase
         end
         ST_M0: begin
            ctrl_o.busb_addr = REG_DPTR;
            ctrl_o.selop     = SEL_PASS_B;
            ctrl_o.mar_en    = 1'b1;
         end
         ST_M1: begin
            ctrl_o.mdr_en = 1'b1;
            if (is_store) begin
               ctrl_o.busb_addr = REG_ACC;
               ctrl_o.selop     = SEL_PASS_B;
            end else begin
               ctrl_o.mdr_alu_n = 1'b1;
            end
         end
         ST_M2: begin
            if (is_store) begin
               ctrl_o.wr_rdn = 1'b1;
            end else begin
               ctrl_o.busc_addr  = REG_ACC;
               ctrl_o.mdr_alu_n  = 1'b1;
               ctrl_o.bank_wr_en = 1'b1;
            end
         end
         ST_SK: begin
            // PC increment is always presented; only the write depends on the flag
            ctrl_o.selop      = SEL_INC_B;
            ctrl_o.busb_addr  = REG_PC;
            ctrl_o.busc_addr  = REG_PC;
            ctrl_o.bank_wr_en = flags_i[instruction_i[1:0]];
         end
         ST_HALT: begin
            ctrl_o.halted = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute microsequencer driving memory_system's control inputs.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   run                  level: leave IDLE / keep fetching
//   instruction          IR opcode; C,N,P,Z ALU flags
//   ir_sclr, mar_sclr    sync clears; enaf flag update enable
//   selop, shamt         ALU op and shift amount
//   bank_wr_en, busB_addr, busC_addr  register bank control
//   ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n  load/memory control
//   halted, state_m      HALT indicator and state monitor
module control_unit
   import control_unit_pkg::*;
#(
   parameter logic [SHAMT_W-1:0] SHIFT_AMT = 2'd1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [OPC_W-1:0]   instruction,
   input  logic               C,
   input  logic               N,
   input  logic               P,
   input  logic               Z,
   output logic               ir_sclr,
   output logic               mar_sclr,
   output logic               enaf,
   output logic [SEL_W-1:0]   selop,
   output logic [SHAMT_W-1:0] shamt,
   output logic               bank_wr_en,
   output logic [ADDR_W-1:0]  busB_addr,
   output logic [ADDR_W-1:0]  busC_addr,
   output logic               ir_en,
   output logic               mar_en,
   output logic               mdr_en,
   output logic               wr_rdn,
   output logic               mdr_alu_n,
   output logic               halted,
   output logic [STATE_W-1:0] state_m
);

   state_e state_q, state_d;
   ctrl_t  ctrl_raw, ctrl_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: if (run) state_d = ST_F0;
         ST_F0:   state_d = ST_F1;
         ST_F1:   state_d = ST_F2;
         ST_F2:   state_d = ST_DEC;
         ST_DEC:  state_d = exec_state(instruction);
         ST_M0:   state_d = ST_M1;
         ST_M1:   state_d = ST_M2;
         ST_EX, ST_M2, ST_SK: state_d = run ? ST_F0 : ST_IDLE;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_INIT;
      endcase
   end

   control_unit_decoder #(
      .SHIFT_AMT(SHIFT_AMT)
   ) u_decoder (
      .state_i      (state_q),
      .instruction_i(instruction),
      .flags_i      ({Z, P, N, C}),
      .ctrl_o       (ctrl_raw)
   );

   // Reset blanks the word in the cycle it is asserted so no partial write escapes
   assign ctrl_c  = rst ? '0 : ctrl_raw;
   assign state_m = rst ? '0 : state_q;

   assign ir_sclr    = ctrl_c.ir_sclr;
   assign mar_sclr   = ctrl_c.mar_sclr;
   assign enaf       = ctrl_c.enaf;
   assign selop      = ctrl_c.selop;
   assign shamt      = ctrl_c.shamt;
   assign bank_wr_en = ctrl_c.bank_wr_en;
   assign busB_addr  = ctrl_c.busb_addr;
   assign busC_addr  = ctrl_c.busc_addr;
   assign ir_en      = ctrl_c.ir_en;
   assign mar_en     = ctrl_c.mar_en;
   assign mdr_en     = ctrl_c.mdr_en;
   assign wr_rdn     = ctrl_c.wr_rdn;
   assign mdr_alu_n  = ctrl_c.mdr_alu_n;
   assign halted     = ctrl_c.halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: reset, fetch, ALU, MOV, LOAD/STORE,
// SKIP on flags, NOPs, HALT and reset mid-instruction.
module tb_control_unit;

   typedef struct packed {
      logic [3:0] st;
      logic       ir_sclr;
      logic       mar_sclr;
      logic       enaf;
      logic [2:0] selop;
      logic [1:0] shamt;
      logic       bank_wr_en;
      logic [2:0] busb;
      logic [2:0] busc;
      logic       ir_en;
      logic       mar_en;
      logic       mdr_en;
      logic       wr_rdn;
      logic       mdr_alu_n;
      logic       halted;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst, run;
   logic [4:0] instruction;
   logic       C, N, P, Z;
   logic       ir_sclr, mar_sclr, enaf, bank_wr_en;
   logic [2:0] selop, busB_addr, busC_addr;
   logic [1:0] shamt;
   logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted;
   logic [3:0] state_m;

   obs_t obs, e;
   int   checks = 0;
   int   errors = 0;

   control_unit #(.SHIFT_AMT(2'd1)) dut (
      .clk(clk), .rst(rst), .run(run), .instruction(instruction),
      .C(C), .N(N), .P(P), .Z(Z),
      .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop),
      .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
      .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
      .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .halted(halted), .state_m(state_m)
   );

   assign obs = {state_m, ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en,
                 busB_addr, busC_addr, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted};

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; instruction = 5'b0; {C, N, P, Z} = 4'b0;
      #1;
      e = '0;
      checks++; if (obs !== e) begin errors++; $display("FAIL rst_hold got %h want %h", obs, e); end
      tick(2);
      checks++; if (obs !== e) begin errors++; $display("FAIL rst_2cyc got %h want %h", obs, e); end
      rst = 1'b0;
      #1;
      e = '0; e.st = 4'd0; e.ir_sclr = 1'b1; e.mar_sclr = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL init got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd1;
      checks++; if (obs !== e) begin errors++; $display("FAIL idle got %h want %h", obs, e); end
      tick(1);
      checks++; if (obs !== e) begin errors++; $display("FAIL idle_hold got %h want %h", obs, e); end
   endtask

   task automatic test_alu();
      instruction = 5'b00100; run = 1'b1;
      tick(1);
      e = '0; e.st = 4'd2; e.mar_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL f0 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd3; e.mdr_alu_n = 1'b1; e.mdr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL f1 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd4; e.ir_en = 1'b1; e.selop = 3'b110; e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL f2 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd5;
      checks++; if (obs !== e) begin errors++; $display("FAIL dec got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd6; e.selop = 3'b100; e.shamt = 2'd1; e.busb = 3'b011;
      e.busc = 3'b111; e.enaf = 1'b1; e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ex_xor got %h want %h", obs, e); end
      instruction = 5'b00111;
      tick(1);
      e = '0; e.st = 4'd2; e.mar_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL b2b_f0 got %h want %h", obs, e); end
      tick(4);
      e = '0; e.st = 4'd6; e.selop = 3'b111; e.shamt = 2'd1; e.busb = 3'b011;
      e.busc = 3'b111; e.enaf = 1'b1; e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ex_shift got %h want %h", obs, e); end
      run = 1'b0;
      tick(1);
      e = '0; e.st = 4'd1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ex_to_idle got %h want %h", obs, e); end
   endtask

   task automatic test_mov();
      instruction = 5'b01000; run = 1'b1;
      tick(5);
      e = '0; e.st = 4'd6; e.busb = 3'b111; e.busc = 3'b000; e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL mov_pc got %h want %h", obs, e); end
      instruction = 5'b01101;
      tick(5);
      e.busc = 3'b101;
      checks++; if (obs !== e) begin errors++; $display("FAIL mov_r5 got %h want %h", obs, e); end
      run = 1'b0;
      tick(1);
   endtask

   task automatic test_store();
      instruction = 5'b10100; run = 1'b1;
      tick(5);
      e = '0; e.st = 4'd7; e.busb = 3'b001; e.mar_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL st_m0 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd8; e.busb = 3'b111; e.mdr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL st_m1 got %h want %h", obs, e); end
      run = 1'b0;
      tick(1);
      e = '0; e.st = 4'd9; e.wr_rdn = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL st_m2 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd1;
      checks++; if (obs !== e) begin errors++; $display("FAIL st_idle got %h want %h", obs, e); end
   endtask

   task automatic test_load_reset();
      instruction = 5'b10000; run = 1'b1;
      tick(5);
      e = '0; e.st = 4'd7; e.busb = 3'b001; e.mar_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ld_m0 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd8; e.mdr_alu_n = 1'b1; e.mdr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ld_m1 got %h want %h", obs, e); end
      tick(1);
      e = '0; e.st = 4'd9; e.busc = 3'b111; e.mdr_alu_n = 1'b1; e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ld_m2 got %h want %h", obs, e); end
      tick(6);
      e = '0; e.st = 4'd8; e.mdr_alu_n = 1'b1; e.mdr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL ld2_m1 got %h want %h", obs, e); end
      rst = 1'b1;
      #1;
      e = '0;
      checks++; if (obs !== e) begin errors++; $display("FAIL rst_in_m1 got %h want %h", obs, e); end
      tick(1);
      checks++; if (obs !== e) begin errors++; $display("FAIL rst_after_m1 got %h want %h", obs, e); end
      rst = 1'b0; run = 1'b0;
      #1;
      e = '0; e.st = 4'd0; e.ir_sclr = 1'b1; e.mar_sclr = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL rst_init got %h want %h", obs, e); end
      tick(1);
   endtask

   task automatic test_skip();
      instruction = 5'b11011; Z = 1'b1; run = 1'b1;
      tick(5);
      e = '0; e.st = 4'd10; e.selop = 3'b110; e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL skip_z1 got %h want %h", obs, e); end
      Z = 1'b0;
      tick(5);
      e.bank_wr_en = 1'b0;
      checks++; if (obs !== e) begin errors++; $display("FAIL skip_z0 got %h want %h", obs, e); end
      instruction = 5'b11000; C = 1'b1;
      tick(5);
      e.bank_wr_en = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL skip_c1 got %h want %h", obs, e); end
      instruction = 5'b11001;
      tick(5);
      e.bank_wr_en = 1'b0;
      checks++; if (obs !== e) begin errors++; $display("FAIL skip_n0 got %h want %h", obs, e); end
      run = 1'b0; C = 1'b0;
      tick(1);
   endtask

   task automatic test_nop();
      instruction = 5'b10001; run = 1'b1;
      tick(5);
      e = '0; e.st = 4'd6;
      checks++; if (obs !== e) begin errors++; $display("FAIL nop_mem got %h want %h", obs, e); end
      instruction = 5'b11100;
      tick(5);
      checks++; if (obs !== e) begin errors++; $display("FAIL nop_ctl got %h want %h", obs, e); end
      run = 1'b0;
      tick(1);
   endtask

   task automatic test_halt();
      instruction = 5'b11111; run = 1'b1;
      tick(5);
      e = '0; e.st = 4'd11; e.halted = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL halt_enter got %h want %h", obs, e); end
      for (int i = 0; i < 20; i++) begin
         tick(1);
         checks++; if (obs !== e) begin errors++; $display("FAIL halt_hold cyc %0d got %h want %h", i, obs, e); end
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      #1;
      e = '0; e.st = 4'd0; e.ir_sclr = 1'b1; e.mar_sclr = 1'b1;
      checks++; if (obs !== e) begin errors++; $display("FAIL halt_rst got %h want %h", obs, e); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mov();
      test_store();
      test_load_reset();
      test_skip();
      test_nop();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
